// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word-organised memory with byte-lane writes, optional
// wait states per data phase and a two-cycle ERROR response for bad transfers.
module ahb_sram_slave #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        i_hclk,
    input  logic        i_hreset_n,
    input  logic        i_hsel,
    input  logic [31:0] i_haddr,
    input  logic [1:0]  i_htrans,
    input  logic        i_hwrite,
    input  logic [2:0]  i_hsize,
    input  logic [2:0]  i_hburst,
    input  logic [31:0] i_hwdata,
    input  logic        i_hready,
    output logic [31:0] o_hrdata,
    output logic        o_hready,
    output logic [1:0]  o_hresp
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {IDLE, WAIT, RESP, ERR1, ERR2} state_t;

    state_t         state;
    logic [3:0]     wait_cnt;
    logic [31:0]    mem [DEPTH];

    logic [AW-1:0]  idx_p1;
    logic [1:0]     lane_p1;
    logic [2:0]     size_p1;
    logic           write_p1;

    logic           accept;
    logic           legal;
    logic           wr_en;
    logic [3:0]     wr_mask;
    logic [AW-1:0]  rd_idx;
    logic [31:0]    rd_word;
    logic           rd_load;
    logic           unused_ok;

    assign unused_ok = ^{i_hburst, i_htrans[0]};

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        case (size)
            3'b000:  return 4'b0001 << a;
            3'b001:  return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = mask[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return res;
    endfunction

    always_comb begin
        accept  = i_hsel && i_hready && i_htrans[1] &&
                  (state == IDLE || state == RESP || state == ERR2);
        legal   = (i_hsize <= 3'b010) &&
                  !(i_hsize == 3'b001 && i_haddr[0]) &&
                  !(i_hsize == 3'b010 && i_haddr[1:0] != 2'b00) &&
                  (i_haddr[31:2] < 30'(DEPTH));
        wr_en   = (state == RESP) && write_p1;
        wr_mask = lane_mask(size_p1, lane_p1);
        // A read accepted in the same cycle a write completes sees the merged word.
        rd_idx  = (state == WAIT) ? idx_p1 : i_haddr[AW+1:2];
        rd_word = mem[rd_idx];
        if (wr_en && idx_p1 == rd_idx)
            rd_word = merge_lanes(rd_word, i_hwdata, wr_mask);
        rd_load = (state == WAIT && wait_cnt <= 4'd1 && !write_p1) ||
                  (accept && legal && !i_hwrite && WAIT_STATES == 0);
    end

    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            o_hready <= 1'b1;
            o_hresp  <= RESP_OKAY;
            o_hrdata <= '0;
        end else begin
            if (rd_load)
                o_hrdata <= rd_word;
            case (state)
                IDLE, RESP, ERR2: begin
                    wait_cnt <= '0;
                    if (!accept) begin
                        state    <= IDLE;
                        o_hready <= 1'b1;
                        o_hresp  <= RESP_OKAY;
                    end else if (!legal) begin
                        state    <= ERR1;
                        o_hready <= 1'b0;
                        o_hresp  <= RESP_ERROR;
                    end else if (WAIT_STATES > 0) begin
                        state    <= WAIT;
                        wait_cnt <= 4'(WAIT_STATES);
                        o_hready <= 1'b0;
                        o_hresp  <= RESP_OKAY;
                    end else begin
                        state    <= RESP;
                        o_hready <= 1'b1;
                        o_hresp  <= RESP_OKAY;
                    end
                end
                WAIT: begin
                    if (wait_cnt <= 4'd1) begin
                        state    <= RESP;
                        wait_cnt <= '0;
                        o_hready <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ERR1: begin
                    state    <= ERR2;
                    o_hready <= 1'b1;
                    o_hresp  <= RESP_ERROR;
                end
                default: begin
                    state    <= IDLE;
                    o_hready <= 1'b1;
                    o_hresp  <= RESP_OKAY;
                end
            endcase
        end
    end

    // Address phase -> data phase
    always_ff @(posedge i_hclk) begin
        if (accept) begin
            idx_p1   <= i_haddr[AW+1:2];
            lane_p1  <= i_haddr[1:0];
            size_p1  <= i_hsize;
            write_p1 <= i_hwrite;
        end
    end

    // Data phase -> memory
    always_ff @(posedge i_hclk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (wr_mask[b])
                    mem[idx_p1][8*b +: 8] <= i_hwdata[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: three instances (0, 3 and 5 wait states) driven one
// at a time, checked every cycle against a transfer-level model.
module tb_ahb_sram_slave;

    localparam int DEPTH = 1024;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    int          cur;

    logic        hsel0, hsel1, hsel2;
    logic [31:0] rd0, rd1, rd2;
    logic        hr0, hr1, hr2;
    logic [1:0]  rs0, rs1, rs2;
    logic [31:0] hrdata_m;
    logic        hready_m;
    logic [1:0]  hresp_m;

    assign hsel0 = hsel && (cur == 0);
    assign hsel1 = hsel && (cur == 1);
    assign hsel2 = hsel && (cur == 2);

    always_comb begin
        case (cur)
            0:       begin hrdata_m = rd0; hready_m = hr0; hresp_m = rs0; end
            1:       begin hrdata_m = rd1; hready_m = hr1; hresp_m = rs1; end
            default: begin hrdata_m = rd2; hready_m = hr2; hresp_m = rs2; end
        endcase
    end

    ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(hsel0), .i_haddr(haddr),
        .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst),
        .i_hwdata(hwdata), .i_hready(hr0), .o_hrdata(rd0), .o_hready(hr0), .o_hresp(rs0));
    ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
        .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(hsel1), .i_haddr(haddr),
        .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst),
        .i_hwdata(hwdata), .i_hready(hr1), .o_hrdata(rd1), .o_hready(hr1), .o_hresp(rs1));
    ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(5)) u_ws5 (
        .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(hsel2), .i_haddr(haddr),
        .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst),
        .i_hwdata(hwdata), .i_hready(hr2), .o_hrdata(rd2), .o_hready(hr2), .o_hresp(rs2));

    // One expected data-phase cycle per entry.
    typedef struct {
        logic        hr;
        logic [1:0]  resp;
        logic        fin;
        logic        wr;
        logic        rd;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [2:0]  size;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mem_m [3][DEPTH];
    logic [31:0] last_rd [3];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] pend = '0;

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 3 : 5;
    endfunction

    function automatic bit is_legal(input logic [31:0] a, input logic [2:0] s);
        if (s > 3'd2) return 1'b0;
        if ((a & ((32'd1 << s) - 32'd1)) != 32'd0) return 1'b0;
        return (a >> 2) < 32'(DEPTH);
    endfunction

    function automatic void apply_write(input int d, input logic [31:0] a,
                                        input logic [2:0] s, input logic [31:0] data);
        int nb, base;
        nb = 1 << s;
        base = int'(a[1:0]);
        for (int b = 0; b < 4; b++)
            if (b >= base && b < base + nb)
                mem_m[d][a[11:2]][8*b +: 8] = data[8*b +: 8];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        logic rdy;
        ent_t e;
        ent_t n;
        if (rst_n) begin
            rdy = (q.size() == 0) ? 1'b1 : q[0].hr;
            if (q.size() != 0) begin
                e = q.pop_front();
                if (e.fin && e.wr) apply_write(cur, e.addr, e.size, hwdata);
                if (e.fin && e.rd) last_rd[cur] = e.rdata;
            end
            if (hsel && htrans[1] && rdy) begin
                n = '{default: '0};
                n.addr = haddr;
                n.size = hsize;
                if (!is_legal(haddr, hsize)) begin
                    n.hr = 1'b0; n.resp = 2'b01; q.push_back(n);
                    n.hr = 1'b1; q.push_back(n);
                end else begin
                    repeat (ws_of(cur)) begin
                        n.hr = 1'b0; q.push_back(n);
                    end
                    n.hr = 1'b1; n.fin = 1'b1; n.wr = hwrite; n.rd = !hwrite;
                    n.rdata = mem_m[cur][haddr[11:2]];
                    q.push_back(n);
                end
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic        ehr;
        logic [1:0]  ers;
        logic [31:0] erd;
        if (!rst_n) begin
            q.delete();
            for (int i = 0; i < 3; i++) last_rd[i] = '0;
            ehr = 1'b1; ers = 2'b00; erd = '0;
        end else if (q.size() == 0) begin
            ehr = 1'b1; ers = 2'b00; erd = last_rd[cur];
        end else begin
            ehr = q[0].hr; ers = q[0].resp;
            erd = (q[0].fin && q[0].rd) ? q[0].rdata : last_rd[cur];
        end
        chk("hready", 32'(hready_m), 32'(ehr));
        chk("hresp", 32'(hresp_m), 32'(ers));
        chk("hrdata", hrdata_m, erd);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one address phase and hold it until an edge with HREADY high.
    task automatic beat(input logic sel, input logic [1:0] tr, input logic wr,
                        input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
        int  n;
        logic ok;
        n = 0;
        hsel = sel; htrans = tr; hwrite = wr; haddr = a; hsize = s;
        hburst = 3'($urandom_range(0, 7));
        hwdata = pend;
        pend = wd;
        do begin
            @(negedge clk);
            ok = hready_m;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 64);
        chk("beat_accept", 32'(ok), 32'd1);
    endtask

    task automatic set_idle();
        hsel = 1'b1; htrans = T_IDLE; hwrite = 1'b0;
        hwdata = pend;
        pend = '0;
    endtask

    initial begin
        logic [2:0]  s;
        logic [31:0] a;
        int          r;
        hsel = 1'b0; haddr = '0; htrans = T_IDLE; hwrite = 1'b0; hsize = 3'd2;
        hburst = '0; hwdata = '0; cur = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hready", 32'(hready_m), 32'd1);
        chk("rst_hresp", 32'(hresp_m), 32'd0);
        chk("rst_hrdata", hrdata_m, 32'd0);
        rst_n = 1'b1;

        for (int d = 0; d < 3; d++) begin
            cur = d;
            for (int w = 0; w < 16; w++)
                beat(1'b1, T_NSEQ, 1'b1, 32'(w * 4), 3'd2, 32'hC0DE_0000 | 32'(w));
            beat(1'b1, T_IDLE, 1'b0, 32'h0, 3'd2, 32'h0);
        end

        // Zero wait states: word, halfword and byte lanes with read-after-write.
        cur = 0;
        beat(1'b1, T_NSEQ, 1'b1, 32'h10, 3'd2, 32'hF0FF_0FAA);
        beat(1'b1, T_NSEQ, 1'b0, 32'h10, 3'd2, 32'h0);
        chk("word_raw", hrdata_m, 32'hF0FF_0FAA);
        beat(1'b1, T_NSEQ, 1'b1, 32'h10, 3'd2, 32'h0000_0000);
        chk("model_pin_word", last_rd[0], 32'hF0FF_0FAA);
        beat(1'b1, T_NSEQ, 1'b1, 32'h12, 3'd1, 32'hF0FF_0000);
        beat(1'b1, T_NSEQ, 1'b0, 32'h10, 3'd2, 32'h0);
        chk("half_lane", hrdata_m, 32'hF0FF_0000);
        beat(1'b1, T_NSEQ, 1'b1, 32'h10, 3'd0, 32'h0000_00AA);
        beat(1'b1, T_NSEQ, 1'b0, 32'h10, 3'd2, 32'h0);
        chk("byte_lane", hrdata_m, 32'hF0FF_00AA);

        // Pipelined burst with a BUSY beat in the middle.
        beat(1'b1, T_NSEQ, 1'b1, 32'h0, 3'd2, 32'h1111_0001);
        beat(1'b1, T_SEQ,  1'b1, 32'h4, 3'd2, 32'h2222_0002);
        beat(1'b1, T_BUSY, 1'b1, 32'h8, 3'd2, 32'h0);
        chk("busy_hready", 32'(hready_m), 32'd1);
        chk("busy_hresp", 32'(hresp_m), 32'd0);
        beat(1'b1, T_SEQ,  1'b1, 32'h8, 3'd2, 32'h3333_0003);
        beat(1'b1, T_NSEQ, 1'b0, 32'h0, 3'd2, 32'h0);
        chk("burst_rd0", hrdata_m, 32'h1111_0001);
        beat(1'b1, T_SEQ,  1'b0, 32'h4, 3'd2, 32'h0);
        chk("burst_rd1", hrdata_m, 32'h2222_0002);
        beat(1'b1, T_SEQ,  1'b0, 32'h8, 3'd2, 32'h0);
        chk("burst_rd2", hrdata_m, 32'h3333_0003);
        beat(1'b1, T_IDLE, 1'b0, 32'h0, 3'd2, 32'h0);
        chk("model_pin_burst", last_rd[0], 32'h3333_0003);

        // Out-of-range write (aliases word 0 in the low bits) and misaligned read.
        beat(1'b1, T_NSEQ, 1'b1, 32'h1000, 3'd2, 32'hBAD0_BAD0);
        set_idle();
        chk("oor_err1_hready", 32'(hready_m), 32'd0);
        chk("oor_err1_hresp", 32'(hresp_m), 32'd1);
        step();
        chk("oor_err2_hready", 32'(hready_m), 32'd1);
        chk("oor_err2_hresp", 32'(hresp_m), 32'd1);
        step();
        beat(1'b1, T_NSEQ, 1'b0, 32'h2, 3'd2, 32'h0);
        set_idle();
        chk("mis_err1_hready", 32'(hready_m), 32'd0);
        chk("mis_err1_hresp", 32'(hresp_m), 32'd1);
        step();
        chk("mis_err2_hready", 32'(hready_m), 32'd1);
        chk("mis_err2_hresp", 32'(hresp_m), 32'd1);
        step();
        beat(1'b1, T_NSEQ, 1'b0, 32'h0, 3'd2, 32'h0);
        chk("err_mem_intact", hrdata_m, 32'h1111_0001);
        beat(1'b1, T_IDLE, 1'b0, 32'h0, 3'd2, 32'h0);

        // Three wait states on a single read.
        cur = 1;
        beat(1'b1, T_NSEQ, 1'b0, 32'h10, 3'd2, 32'h0);
        set_idle();
        for (int i = 0; i < 3; i++) begin
            chk("ws3_low", 32'(hready_m), 32'd0);
            step();
        end
        chk("ws3_high", 32'(hready_m), 32'd1);
        chk("ws3_data", hrdata_m, 32'hC0DE_0004);
        step();

        // Reset during the wait phase of a write.
        cur = 2;
        beat(1'b1, T_NSEQ, 1'b1, 32'h20, 3'd2, 32'hDEAD_BEEF);
        set_idle();
        hwdata = 32'hDEAD_BEEF;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_hready", 32'(hready_m), 32'd1);
        chk("arst_hresp", 32'(hresp_m), 32'd0);
        chk("arst_hrdata", hrdata_m, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        beat(1'b1, T_NSEQ, 1'b0, 32'h20, 3'd2, 32'h0);
        beat(1'b1, T_IDLE, 1'b0, 32'h0, 3'd2, 32'h0);
        chk("arst_word_kept", hrdata_m, 32'hC0DE_0008);

        // Randomised traffic on each instance.
        for (int d = 0; d < 3; d++) begin
            cur = d;
            for (int i = 0; i < 250; i++) begin
                s = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7))
                                                 : 3'($urandom_range(0, 2));
                r = $urandom_range(0, 19);
                if (r == 0)
                    a = 32'h1000 + 32'($urandom_range(0, 63));
                else if (r == 1)
                    a = $urandom | 32'h0001_0000;
                else begin
                    a = 32'($urandom_range(0, 63));
                    if (s <= 3'd2 && $urandom_range(0, 3) != 0)
                        a = a & ~((32'd1 << s) - 32'd1);
                end
                r = $urandom_range(0, 9);
                beat(($urandom_range(0, 9) != 0),
                     (r == 0) ? T_IDLE : (r == 1) ? T_BUSY : (r < 6) ? T_NSEQ : T_SEQ,
                     1'($urandom_range(0, 1)), a, s, $urandom);
            end
            beat(1'b1, T_IDLE, 1'b0, 32'h0, 3'd2, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
